// File: rtl/tlb_isr_chunker_if.sv
// Request/completion bundle between the TLB FSM, the chunker and the ISR arbiter.
// The request side flows master -> slave; the completion side flows slave -> master.
interface tlb_isr_chunker_if #(
    parameter int unsigned PADDR_BITS = 40,
    parameter int unsigned LEN_BITS   = 28,
    parameter int unsigned PID_BITS   = 6,
    parameter int unsigned DEST_BITS  = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic [PADDR_BITS-1:0] req_paddr_host;
    logic [PADDR_BITS-1:0] req_paddr_card;
    logic [LEN_BITS-1:0]   req_len;
    logic                  req_ctl;
    logic [PID_BITS-1:0]   req_pid;
    logic [DEST_BITS-1:0]  req_dest;
    logic                  req_stream;
    logic                  req_host;

    logic                  rsp_done;
    logic [PID_BITS-1:0]   rsp_pid;
    logic [DEST_BITS-1:0]  rsp_dest;
    logic                  rsp_stream;
    logic                  rsp_host;

    modport master (
        output req_valid, req_paddr_host, req_paddr_card, req_len, req_ctl,
               req_pid, req_dest, req_stream, req_host,
        input  req_ready,
        input  rsp_done, rsp_pid, rsp_dest, rsp_stream, rsp_host
    );

    modport slave (
        input  req_valid, req_paddr_host, req_paddr_card, req_len, req_ctl,
               req_pid, req_dest, req_stream, req_host,
        output req_ready,
        output rsp_done, rsp_pid, rsp_dest, rsp_stream, rsp_host
    );
endinterface

// File: rtl/tlb_isr_chunker.sv
// Splits one host<->card migration request into chunk requests that never cross
// a 2**CHUNK_BITS boundary on either side; only the last chunk carries ctl.
// Completions from the arbiter are registered back to the TLB FSM independently.
module tlb_isr_chunker #(
    parameter int unsigned PADDR_BITS = 40,
    parameter int unsigned LEN_BITS   = 28,
    parameter int unsigned CHUNK_BITS = 12,
    parameter int unsigned PID_BITS   = 6,
    parameter int unsigned DEST_BITS  = 4
) (
    input  logic                aclk,
    input  logic                areset,
    tlb_isr_chunker_if.slave    s,
    tlb_isr_chunker_if.master   m,
    output logic                len_err,
    output logic                busy
);

    localparam int unsigned LW1 = LEN_BITS + 1;
    localparam logic [LW1-1:0] CHUNK_BYTES = LW1'(1) << CHUNK_BITS;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    // Bytes allowed in the next chunk: bounded by remaining length and both boundaries.
    function automatic logic [LW1-1:0] chunk_len(
        input logic [CHUNK_BITS-1:0] host_lo,
        input logic [CHUNK_BITS-1:0] card_lo,
        input logic [LEN_BITS-1:0]   rem
    );
        logic [LW1-1:0] host_room;
        logic [LW1-1:0] card_room;
        logic [LW1-1:0] clen;
        host_room = CHUNK_BYTES - LW1'(host_lo);
        card_room = CHUNK_BYTES - LW1'(card_lo);
        clen      = LW1'(rem);
        if (host_room < clen) clen = host_room;
        if (card_room < clen) clen = card_room;
        return clen;
    endfunction

    state_e                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  len_err_q, len_err_d;
    logic                  mvalid_q, mvalid_d;
    logic [PADDR_BITS-1:0] host_q, host_d;
    logic [PADDR_BITS-1:0] card_q, card_d;
    logic [LEN_BITS-1:0]   rem_q, rem_d;
    logic [LEN_BITS-1:0]   len_q, len_d;
    logic                  last_q, last_d;
    logic                  ctl_q, ctl_d;
    logic                  mctl_q, mctl_d;
    logic [PID_BITS-1:0]   pid_q, pid_d;
    logic [DEST_BITS-1:0]  dest_q, dest_d;
    logic                  stream_q, stream_d;
    logic                  hostf_q, hostf_d;

    logic [PADDR_BITS-1:0] nxt_host;
    logic [PADDR_BITS-1:0] nxt_card;
    logic [LEN_BITS-1:0]   nxt_rem;
    logic                  ctl_src;
    logic                  load;
    logic [LW1-1:0]        clen;
    logic                  nxt_last;

    logic                  rsp_done_q;
    logic [PID_BITS-1:0]   rsp_pid_q;
    logic [DEST_BITS-1:0]  rsp_dest_q;
    logic                  rsp_stream_q;
    logic                  rsp_host_q;

    // State and request-side registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            len_err_q <= 1'b0;
            mvalid_q  <= 1'b0;
            host_q    <= '0;
            card_q    <= '0;
            rem_q     <= '0;
            len_q     <= '0;
            last_q    <= 1'b0;
            ctl_q     <= 1'b0;
            mctl_q    <= 1'b0;
            pid_q     <= '0;
            dest_q    <= '0;
            stream_q  <= 1'b0;
            hostf_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            len_err_q <= len_err_d;
            mvalid_q  <= mvalid_d;
            host_q    <= host_d;
            card_q    <= card_d;
            rem_q     <= rem_d;
            len_q     <= len_d;
            last_q    <= last_d;
            ctl_q     <= ctl_d;
            mctl_q    <= mctl_d;
            pid_q     <= pid_d;
            dest_q    <= dest_d;
            stream_q  <= stream_d;
            hostf_q   <= hostf_d;
        end
    end

    // Next state: accept in IDLE, advance one chunk per handshake in SPLIT.
    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        len_err_d = 1'b0;
        mvalid_d  = mvalid_q;
        host_d    = host_q;
        card_d    = card_q;
        rem_d     = rem_q;
        len_d     = len_q;
        last_d    = last_q;
        ctl_d     = ctl_q;
        mctl_d    = mctl_q;
        pid_d     = pid_q;
        dest_d    = dest_q;
        stream_d  = stream_q;
        hostf_d   = hostf_q;
        nxt_host  = host_q;
        nxt_card  = card_q;
        nxt_rem   = rem_q;
        ctl_src   = ctl_q;
        load      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (s.req_valid) begin
                    if (s.req_len == '0) begin
                        len_err_d = 1'b1;
                    end else begin
                        nxt_host = s.req_paddr_host;
                        nxt_card = s.req_paddr_card;
                        nxt_rem  = s.req_len;
                        ctl_src  = s.req_ctl;
                        ctl_d    = s.req_ctl;
                        pid_d    = s.req_pid;
                        dest_d   = s.req_dest;
                        stream_d = s.req_stream;
                        hostf_d  = s.req_host;
                        load     = 1'b1;
                        state_d  = SPLIT;
                        ready_d  = 1'b0;
                        busy_d   = 1'b1;
                    end
                end
            end
            SPLIT: begin
                if (mvalid_q && m.req_ready) begin
                    if (last_q) begin
                        state_d  = IDLE;
                        mvalid_d = 1'b0;
                        ready_d  = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        nxt_host = host_q + PADDR_BITS'(len_q);
                        nxt_card = card_q + PADDR_BITS'(len_q);
                        nxt_rem  = rem_q - len_q;
                        load     = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        clen     = chunk_len(nxt_host[CHUNK_BITS-1:0], nxt_card[CHUNK_BITS-1:0], nxt_rem);
        nxt_last = (LW1'(nxt_rem) == clen);

        if (load) begin
            host_d   = nxt_host;
            card_d   = nxt_card;
            rem_d    = nxt_rem;
            len_d    = LEN_BITS'(clen);
            last_d   = nxt_last;
            mctl_d   = ctl_src & nxt_last;
            mvalid_d = 1'b1;
        end
    end

    // Completion path: one-cycle registered copy, independent of the FSM.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rsp_done_q   <= 1'b0;
            rsp_pid_q    <= '0;
            rsp_dest_q   <= '0;
            rsp_stream_q <= 1'b0;
            rsp_host_q   <= 1'b0;
        end else begin
            rsp_done_q   <= m.rsp_done;
            rsp_pid_q    <= m.rsp_pid;
            rsp_dest_q   <= m.rsp_dest;
            rsp_stream_q <= m.rsp_stream;
            rsp_host_q   <= m.rsp_host;
        end
    end

    assign s.req_ready      = ready_q;
    assign s.rsp_done       = rsp_done_q;
    assign s.rsp_pid        = rsp_pid_q;
    assign s.rsp_dest       = rsp_dest_q;
    assign s.rsp_stream     = rsp_stream_q;
    assign s.rsp_host       = rsp_host_q;

    assign m.req_valid      = mvalid_q;
    assign m.req_paddr_host = host_q;
    assign m.req_paddr_card = card_q;
    assign m.req_len        = len_q;
    assign m.req_ctl        = mctl_q;
    assign m.req_pid        = pid_q;
    assign m.req_dest       = dest_q;
    assign m.req_stream     = stream_q;
    assign m.req_host       = hostf_q;

    assign len_err          = len_err_q;
    assign busy             = busy_q;

endmodule
